// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-write scoreboard beside the ID stage.
// Tracks in-flight writes for the stages after ID. From them it derives a forward
// select for each ID source operand and a stall for ID.
// Optional feature: define HAZARD_PERF_EN to add the stall_cnt_o stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned RDYW   = 2,
    parameter int unsigned SP_REG = 15,
    localparam int unsigned RW    = $clog2(NREGS),
    localparam int unsigned FW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [RW-1:0]   id_rd_i,
    input  logic            id_wr_i,
    input  logic            id_sp_wr_i,
    input  logic [RDYW-1:0] id_rdy_i,
    input  logic [RW-1:0]   id_src_a_i,
    input  logic            id_use_a_i,
    input  logic [RW-1:0]   id_src_b_i,
    input  logic            id_use_b_i,
    input  logic            mem_wait_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [FW-1:0]   fwd_a_o,
`ifdef HAZARD_PERF_EN
    output logic [FW-1:0]   fwd_b_o,
    output logic [31:0]     stall_cnt_o
`else
    output logic [FW-1:0]   fwd_b_o
`endif
);

    typedef struct packed {
        logic          nr;   // youngest producer not yet forwardable
        logic [FW-1:0] fwd;
    } src_res_t;

    // Entry 0 is EXE; entry DEPTH-1 is the last stage before the regfile write.
    logic            r_v   [DEPTH];
    logic            r_wr  [DEPTH];
    logic            r_sp  [DEPTH];
    logic [RW-1:0]   r_rd  [DEPTH];
    logic [RDYW-1:0] r_rdy [DEPTH];

    src_res_t w_res_a;
    src_res_t w_res_b;
    logic     w_stall;

    // Scan from youngest to oldest. The first hit decides; older producers are shadowed.
    function automatic src_res_t lookup(input logic [RW-1:0] src, input logic use_src);
        src_res_t res;
        logic     hit;
        res = '0;
        hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!hit && use_src && r_v[i] &&
                ((r_wr[i] && (r_rd[i] == src)) || (r_sp[i] && (src == RW'(SP_REG))))) begin
                hit = 1'b1;
                if (int'(r_rdy[i]) <= i) begin
                    res.fwd = FW'(i + 1);
                end else begin
                    res.nr = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Forward selects and the stall, computed from the tracked entries and the ID operands.
    always_comb begin
        w_res_a = lookup(id_src_a_i, id_use_a_i);
        w_res_b = lookup(id_src_b_i, id_use_b_i);
        w_stall = id_valid_i && (w_res_a.nr || w_res_b.nr);
        stall_o = w_stall;
        fwd_a_o = w_stall ? '0 : w_res_a.fwd;
        fwd_b_o = w_stall ? '0 : w_res_b.fwd;
    end

    // Entry pipeline: flush beats freeze; freeze beats stall; a stall injects a bubble into EXE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_v[i]   <= 1'b0;
                r_wr[i]  <= 1'b0;
                r_sp[i]  <= 1'b0;
                r_rd[i]  <= '0;
                r_rdy[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_v[i] <= 1'b0;
            end
        end else if (!mem_wait_i) begin
            for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
                r_v[i]   <= r_v[i-1];
                r_wr[i]  <= r_wr[i-1];
                r_sp[i]  <= r_sp[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_rdy[i] <= r_rdy[i-1];
            end
            if (w_stall) begin
                r_v[0] <= 1'b0;
            end else begin
                r_v[0] <= id_valid_i & (id_wr_i | id_sp_wr_i);
            end
            r_wr[0]  <= id_wr_i;
            r_sp[0]  <= id_sp_wr_i;
            r_rd[0]  <= id_rd_i;
            r_rdy[0] <= id_rdy_i;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count only stall cycles that actually cost an issue slot (not frozen, not flushed).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !mem_wait_i && !flush_i) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
